// File: rtl/cgra_loop_ctrl.sv
// cgra_loop_ctrl
//   Sequences one mapped dataflow kernel (ALU / reg_unit / Mem / const_unit
//   graph plus its loop compare). It drives the kernel's shared global_en and
//   global_rst nets, issues loop iterations, and handles pipeline fill, stall
//   and drain. Completion and performance counts go back to the host over a
//   start/done handshake.
//
// Ports
//   clk           kernel clock
//   rst_n         asynchronous active-low reset
//   start         launch request, sampled only in IDLE
//   abort         terminates a running kernel (CLEAR/RUN/DRAIN only)
//   trip_count    iteration count, latched on accepted start
//   pipe_depth    kernel register depth in cycles, latched on accepted start
//   stall         memory/IO not ready; freezes the datapath
//   global_en     enable to every reg_unit in the kernel
//   global_rst    synchronous clear to kernel reg_units and Mem
//   iter_idx      index of the iteration issued this cycle
//   issue         an iteration is issued this cycle
//   busy          high in CLEAR, RUN, DRAIN
//   done          one-cycle completion pulse
//   aborted       qualifies done; held until next accepted start
//   active_cycles cycles with global_en=1 in the last/current run (saturating)
//   stall_cycles  cycles in RUN/DRAIN with stall=1 (saturating)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// CLEAR | one cycle of global_rst before the first iteration
// RUN   | issuing iterations 0 .. trip-1
// DRAIN | last iteration issued, waiting pipe_depth enabled cycles
// DONE  | one-cycle done pulse, then back to IDLE

module cgra_loop_ctrl #(
  parameter int WIDTH = 32,
  parameter int LAT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] trip_count,
  input  logic [LAT_W-1:0] pipe_depth,
  input  logic             stall,
  output logic             global_en,
  output logic             global_rst,
  output logic [WIDTH-1:0] iter_idx,
  output logic             issue,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] active_cycles,
  output logic [WIDTH-1:0] stall_cycles
);

  localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0] L_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] trip_q;
  logic [LAT_W-1:0] depth_q;
  logic [LAT_W-1:0] drain_q;
  logic [WIDTH-1:0] iter_q;
  logic [WIDTH-1:0] active_q;
  logic [WIDTH-1:0] stall_q;
  logic             aborted_q;

  logic start_ok;
  logic in_busy;
  logic run_or_drain;
  logic at_last;
  logic last_issue;

  assign start_ok     = (state_q == S_IDLE) && start;
  assign in_busy      = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign run_or_drain = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign at_last      = (iter_q == (trip_q - W_ONE));
  assign last_issue   = (state_q == S_RUN) && !stall && at_last;

  always_comb begin
    state_d    = state_q;
    global_en  = 1'b0;
    global_rst = 1'b0;
    issue      = 1'b0;
    busy       = in_busy;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        global_rst = 1'b1;
        if (abort || (trip_q == '0)) state_d = S_DONE;
        else                         state_d = S_RUN;
      end
      S_RUN: begin
        global_en = ~stall;
        issue     = ~stall;
        if (abort)           state_d = S_DONE;
        else if (last_issue) state_d = (depth_q == '0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        global_en = ~stall;
        if (abort)                            state_d = S_DONE;
        else if (!stall && (drain_q == L_ONE)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      trip_q    <= '0;
      depth_q   <= '0;
      drain_q   <= '0;
      iter_q    <= '0;
      active_q  <= '0;
      stall_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (start_ok) begin
        trip_q    <= trip_count;
        depth_q   <= pipe_depth;
        iter_q    <= '0;
        active_q  <= '0;
        stall_q   <= '0;
        aborted_q <= 1'b0;
      end

      if (in_busy && abort) aborted_q <= 1'b1;

      // The last iteration's index is kept visible through DRAIN and DONE;
      // an aborting cycle also freezes the index.
      if (issue && !abort && !at_last) iter_q <= iter_q + W_ONE;

      if (last_issue && !abort) drain_q <= depth_q;
      else if ((state_q == S_DRAIN) && !stall && (drain_q != '0)) drain_q <= drain_q - L_ONE;

      if (global_en && (active_q != '1)) active_q <= active_q + W_ONE;
      if (run_or_drain && stall && (stall_q != '1)) stall_q <= stall_q + W_ONE;
    end
  end

  assign iter_idx      = iter_q;
  assign aborted       = aborted_q;
  assign active_cycles = active_q;
  assign stall_cycles  = stall_q;

endmodule

// File: doc/cgra_loop_ctrl.md
Name: cgra_loop_ctrl

Overview:
- Sequences one mapped dataflow kernel: ALU/reg_unit/Mem/const_unit graph plus loop compare.
- Drives the kernel's shared global_en and global_rst nets.
- Counts loop iterations and handles pipeline fill, stall and drain.
- Reports completion and performance counts to the host over a start/done handshake.

Parameters:
- WIDTH, 32, width of trip count, iteration index and performance counters.
- LAT_W, 6, width of the pipeline-depth (drain) counter.

Ports:
- clk  input  1  kernel clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  launch request; sampled only in IDLE.
- abort  input  1  terminates a running kernel; ignored in IDLE and DONE.
- trip_count  input  WIDTH  iteration count (unsigned), latched on accepted start.
- pipe_depth  input  LAT_W  kernel register depth (cycles to drain), latched on accepted start.
- stall  input  1  memory/IO not ready; freezes the datapath.
- global_en  output  1  enable to every reg_unit in the kernel.
- global_rst  output  1  synchronous active-high clear to kernel reg_units and Mem reset.
- iter_idx  output  WIDTH  index of the iteration issued this cycle.
- issue  output  1  an iteration is issued this cycle.
- busy  output  1  high in CLEAR, RUN, DRAIN.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  qualifies done; held until next accepted start.
- active_cycles  output  WIDTH  cycles with global_en=1 during the last or current run.
- stall_cycles  output  WIDTH  cycles in RUN/DRAIN with stall=1.

Behaviour:
- Reset: all outputs 0, state IDLE, latched trip/depth 0. Asynchronous assertion; release synchronous to clk. Reset mid-run abandons the run with no done pulse.
- All outputs are registered or decoded from registered state only. No combinational path from stall to global_en beyond one AND with state: global_en = state∈{RUN,DRAIN} & ~stall.
- IDLE:
  - start=1 latches trip_count and pipe_depth, clears both perf counters and aborted, then goes to CLEAR.
  - start in any other state is ignored; it is not queued.
- CLEAR: exactly one cycle. global_rst=1, global_en=0, iter_idx=0.
  - Next state is DONE if latched trip=0, else RUN.
- RUN:
  - issue = ~stall. iter_idx increments by 1 after each issued cycle.
  - On an issue with iter_idx = trip-1: load the drain counter with depth and go to DRAIN, or go to DONE if depth=0.
  - stall=1 holds iter_idx, issue=0, global_en=0, and increments stall_cycles.
- DRAIN:
  - issue=0, global_en=~stall. The drain counter decrements on each non-stalled cycle.
  - When the counter is 1 and not stalled, go to DONE.
  - iter_idx holds at trip-1.
- DONE: done=1 for exactly one cycle, busy=0, global_en=0, then IDLE.
  - Perf counters hold their values until the next accepted start.
- abort=1 in CLEAR/RUN/DRAIN: next state DONE, aborted=1, global_en=0 from the next cycle. abort wins over a simultaneous last issue.
- active_cycles increments on every cycle with global_en=1. Both counters saturate at all-ones; they do not wrap.
- Simultaneous stall and abort: abort takes effect. Simultaneous start and done cycle: start is ignored because the state is not IDLE.
- Total latency, no stall, trip=N≥1, depth=D: start accepted at cycle 0, CLEAR at cycle 1, issues at cycles 2..N+1, done at cycle N+D+2.

Test Plan:
- trip=4, depth=3, no stall: start at c0 -> global_rst high c1 only; issue c2–c5 with iter_idx 0,1,2,3; drain c6–c8; done c9; active_cycles=7, stall_cycles=0.
- trip=4, depth=3, stall high for 2 cycles at c3: iter_idx holds 1 through the stall, global_en=0 those cycles; done at c11; stall_cycles=2, active_cycles=7.
- trip=0 and pipe_depth=5: CLEAR one cycle, then done; no issue, active_cycles=0. trip=3, depth=0: done the cycle after the third issue.
- abort asserted at the second RUN cycle of trip=10: done next cycle with aborted=1, global_en=0 afterwards; start while busy is ignored; a fresh start clears aborted.
- rst_n pulled low in DRAIN: all outputs 0 immediately, no done; after release, start with trip=1, depth=1 -> done at c4.
- Counter saturation with WIDTH=4, trip=15, depth=5: active_cycles saturates at 15 and does not wrap.
